// File: rtl/mdu_pkg.sv
// Shared multiply/divide unit definitions: Funct3 encodings and the buffered result entry.
package mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;

  localparam int MDU_XLEN = 32;
  localparam int MDU_TAGW = 5;

  // Entry layout for the default datapath; the stage re-derives it from its own parameters.
  typedef struct packed {
    logic [MDU_XLEN-1:0] result;
    logic [MDU_TAGW-1:0] rd;
  } mul_entry_t;

endpackage

// File: rtl/mul_result_fifo.sv
// Small in-order result buffer: storage, wrapping pointers, occupancy count, full/empty.
module mul_result_fifo #(
  parameter type T     = logic [31:0],
  parameter int  DEPTH = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enq,
  input  T     enq_data,
  input  logic deq,
  output T     head,
  output logic full,
  output logic empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        mem[wr_ptr] <= enq_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (deq) rd_ptr <= ptr_inc(rd_ptr);
      // Simultaneous enq/deq leaves the count alone while both pointers advance.
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/mul_result_stage.sv
// Multiplier result stage: E->M sideband, low/high half select, 2-entry writeback buffer.
// Optional MUL_W_OPS_EN (XLEN=64 only) adds sign-extended MULW results.
module mul_result_stage
  import mdu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int TAGW = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              StallM,
  input  logic              FlushM,
  input  logic              MulValidE,
  input  logic [2:0]        Funct3E,
  input  logic              W64E,
  input  logic [TAGW-1:0]   RdE,
  input  logic [2*XLEN-1:0] ProdM,
  input  logic              MulResultReadyW,
  output logic              MulResultValidW,
  output logic [XLEN-1:0]   MulResultW,
  output logic [TAGW-1:0]   MulRdW,
  output logic              MulBusyM
);

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [TAGW-1:0] rd;
  } entry_t;

  logic            MulValidM;
  logic [2:0]      Funct3M;
  logic [TAGW-1:0] RdM;
  logic [XLEN-1:0] sel_result;
  logic            EnqM, DeqW, full, empty;
  entry_t          enq_entry, head;

`ifdef MUL_W_OPS_EN
  logic W64M;
`else
  logic unused_w64;
  assign unused_w64 = W64E;
`endif

  // Same enable as the product registers so ProdM and the sideband line up in M.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      MulValidM <= 1'b0;
      Funct3M   <= '0;
      RdM       <= '0;
`ifdef MUL_W_OPS_EN
      W64M      <= 1'b0;
`endif
    end else if (FlushM) begin
      MulValidM <= 1'b0;
      Funct3M   <= '0;
      RdM       <= '0;
`ifdef MUL_W_OPS_EN
      W64M      <= 1'b0;
`endif
    end else if (!StallM) begin
      MulValidM <= MulValidE;
      Funct3M   <= Funct3E;
      RdM       <= RdE;
`ifdef MUL_W_OPS_EN
      W64M      <= W64E;
`endif
    end
  end

  always_comb begin
    sel_result = ProdM[XLEN-1:0];
    case (Funct3M)
      MDU_MULH, MDU_MULHSU, MDU_MULHU: sel_result = ProdM[2*XLEN-1:XLEN];
      default: ;
    endcase
`ifdef MUL_W_OPS_EN
    if (W64M && Funct3M == MDU_MUL) sel_result = {{(XLEN-32){ProdM[31]}}, ProdM[31:0]};
`endif
  end

  assign enq_entry = '{result: sel_result, rd: RdM};
  assign EnqM      = MulValidM & ~StallM & ~FlushM & ~full;
  assign DeqW      = MulResultValidW & MulResultReadyW;

  mul_result_fifo #(.T(entry_t), .DEPTH(2)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .enq      (EnqM),
    .enq_data (enq_entry),
    .deq      (DeqW),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  assign MulResultValidW = ~empty;
  assign MulResultW      = head.result;
  assign MulRdW          = head.rd;
  assign MulBusyM        = full;

`ifndef SYNTHESIS
  // The hazard unit must stall M while busy; an unstalled valid op against a full buffer is lost.
  enq_while_full: assert property (@(posedge clk) disable iff (!reset_n)
    !(MulValidM && !StallM && !FlushM && full));
`endif

endmodule

// File: tb/tb_mul_result_stage.sv
// Scoreboard bench for mul_result_stage; XLEN follows MUL_W_OPS_EN (64 when defined, else 32).
module tb_mul_result_stage;

`ifdef MUL_W_OPS_EN
  localparam int XLEN = 64;
`else
  localparam int XLEN = 32;
`endif
  localparam int TAGW = 5;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              StallM = 1'b0, FlushM = 1'b0, MulValidE = 1'b0, W64E = 1'b0;
  logic [2:0]        Funct3E = '0;
  logic [TAGW-1:0]   RdE = '0;
  logic [2*XLEN-1:0] ProdM = '0;
  logic              MulResultReadyW = 1'b0;
  logic              MulResultValidW, MulBusyM;
  logic [XLEN-1:0]   MulResultW;
  logic [TAGW-1:0]   MulRdW;

  typedef struct {
    logic [XLEN-1:0] res;
    logic [TAGW-1:0] rd;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mul_result_stage #(.XLEN(XLEN), .TAGW(TAGW)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .StallM          (StallM),
    .FlushM          (FlushM),
    .MulValidE       (MulValidE),
    .Funct3E         (Funct3E),
    .W64E            (W64E),
    .RdE             (RdE),
    .ProdM           (ProdM),
    .MulResultReadyW (MulResultReadyW),
    .MulResultValidW (MulResultValidW),
    .MulResultW      (MulResultW),
    .MulRdW          (MulRdW),
    .MulBusyM        (MulBusyM)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Put an op in E for one edge, then present its product in M.
  task automatic drive_op(input logic [2:0] f3, input logic w64, input logic [TAGW-1:0] rd,
                          input logic [2*XLEN-1:0] p);
    MulValidE = 1'b1; Funct3E = f3; W64E = w64; RdE = rd;
    tick;
    MulValidE = 1'b0; Funct3E = '0; W64E = 1'b0; RdE = '0; ProdM = p;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #2;
    checks++; if (MulResultValidW !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", MulResultValidW); end
    checks++; if (MulBusyM !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", MulBusyM); end
    checks++; if (MulResultW !== '0) begin errors++; $display("FAIL reset_result: got %h want 0", MulResultW); end
    checks++; if (MulRdW !== '0) begin errors++; $display("FAIL reset_rd: got %0d want 0", MulRdW); end
    repeat (2) tick;
    reset_n = 1'b1;
    tick;
    checks++; if (MulResultValidW !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b want 0", MulResultValidW); end
  endtask

  task automatic test_select;
    logic [XLEN-1:0]   m1, m3, two;
    logic [2:0]        f3s [5];
    logic [2*XLEN-1:0] prods [5];
    logic [XLEN-1:0]   exps [5];
    exp_t e;
    m1 = '1; two = XLEN'(2); m3 = m1 - XLEN'(2);
    f3s   = '{3'b000, 3'b011, 3'b001, 3'b010, 3'b111};
    prods = '{{two, m3}, {two, m3}, {m1, m3}, {two, m3}, {two, m3}};
    exps  = '{m3, two, m1, two, m3};
    MulResultReadyW = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_op(f3s[i], 1'b0, TAGW'(5 + i), prods[i]);
      sb.push_back('{exps[i], TAGW'(5 + i)});
      checks++; if (MulResultValidW !== 1'b0) begin errors++; $display("FAIL select_no_bypass[%0d]: valid got %b want 0", i, MulResultValidW); end
      tick;
      e = sb.pop_front();
      checks++;
      if (MulResultValidW !== 1'b1 || MulResultW !== e.res || MulRdW !== e.rd) begin
        errors++;
        $display("FAIL select[%0d]: got v=%b res=%h rd=%0d want v=1 res=%h rd=%0d", i, MulResultValidW, MulResultW, MulRdW, e.res, e.rd);
      end
    end
    tick;
    checks++; if (MulResultValidW !== 1'b0) begin errors++; $display("FAIL select_drained: valid got %b want 0", MulResultValidW); end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    MulResultReadyW = 1'b0;
    MulValidE = 1'b1; Funct3E = 3'b000; W64E = 1'b0; RdE = 1;
    tick;
    ProdM = {XLEN'(0), XLEN'(32'h11)}; RdE = 2;
    sb.push_back('{XLEN'(32'h11), TAGW'(1)});
    tick;
    ProdM = {XLEN'(0), XLEN'(32'h22)}; RdE = 3;
    sb.push_back('{XLEN'(32'h22), TAGW'(2)});
    tick;
    MulValidE = 1'b0; RdE = '0; ProdM = {XLEN'(0), XLEN'(32'h33)};
    StallM = MulBusyM;
    checks++; if (MulBusyM !== 1'b1) begin errors++; $display("FAIL b2b_busy_full: got %b want 1", MulBusyM); end
    repeat (2) begin
      checks++;
      if (MulResultValidW !== 1'b1 || MulRdW !== sb[0].rd || MulResultW !== sb[0].res) begin
        errors++;
        $display("FAIL b2b_head_hold: got v=%b res=%h rd=%0d want v=1 res=%h rd=%0d", MulResultValidW, MulResultW, MulRdW, sb[0].res, sb[0].rd);
      end
      tick;
      StallM = MulBusyM;
    end
    checks++; if (MulBusyM !== 1'b1) begin errors++; $display("FAIL b2b_busy_held: got %b want 1", MulBusyM); end
    MulResultReadyW = 1'b1;
    tick;
    e = sb.pop_front();
    StallM = MulBusyM;
    checks++; if (MulBusyM !== 1'b0) begin errors++; $display("FAIL b2b_busy_drop: got %b want 0", MulBusyM); end
    sb.push_back('{XLEN'(32'h33), TAGW'(3)});
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (MulResultValidW !== 1'b1 || MulRdW !== sb[0].rd || MulResultW !== sb[0].res) begin
        errors++;
        $display("FAIL b2b_order[%0d]: got v=%b res=%h rd=%0d want v=1 res=%h rd=%0d", k, MulResultValidW, MulResultW, MulRdW, sb[0].res, sb[0].rd);
      end
      tick;
      e = sb.pop_front();
      StallM = MulBusyM;
    end
    checks++; if (MulResultValidW !== 1'b0) begin errors++; $display("FAIL b2b_drained: valid got %b want 0", MulResultValidW); end
    StallM = 1'b0;
  endtask

  task automatic test_flush_stall;
    exp_t e;
    MulResultReadyW = 1'b1;
    drive_op(3'b000, 1'b0, TAGW'(10), {XLEN'(0), XLEN'(32'h44)});
    FlushM = 1'b1;
    tick;
    FlushM = 1'b0;
    checks++; if (MulResultValidW !== 1'b0) begin errors++; $display("FAIL flush_no_enq: valid got %b want 0", MulResultValidW); end
    tick;
    checks++; if (MulResultValidW !== 1'b0) begin errors++; $display("FAIL flush_cleared: valid got %b want 0", MulResultValidW); end
    // Flush takes priority over a concurrent stall.
    drive_op(3'b000, 1'b0, TAGW'(9), {XLEN'(0), XLEN'(32'h55)});
    StallM = 1'b1; FlushM = 1'b1;
    tick;
    StallM = 1'b0; FlushM = 1'b0;
    tick;
    checks++; if (MulResultValidW !== 1'b0) begin errors++; $display("FAIL flush_over_stall: valid got %b want 0", MulResultValidW); end
    drive_op(3'b000, 1'b0, TAGW'(11), {XLEN'(0), XLEN'(32'h5A)});
    StallM = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++; if (MulResultValidW !== 1'b0) begin errors++; $display("FAIL stall_hold[%0d]: valid got %b want 0", k, MulResultValidW); end
    end
    sb.push_back('{XLEN'(32'h5A), TAGW'(11)});
    StallM = 1'b0;
    tick;
    e = sb.pop_front();
    checks++;
    if (MulResultValidW !== 1'b1 || MulResultW !== e.res || MulRdW !== e.rd) begin
      errors++;
      $display("FAIL stall_release: got v=%b res=%h rd=%0d want v=1 res=%h rd=%0d", MulResultValidW, MulResultW, MulRdW, e.res, e.rd);
    end
    tick;
    checks++; if (MulResultValidW !== 1'b0) begin errors++; $display("FAIL stall_no_dup: valid got %b want 0", MulResultValidW); end
  endtask

  task automatic test_wops;
    logic [XLEN-1:0]   lo, hi;
    logic [2*XLEN-1:0] p;
    logic [XLEN-1:0]   w_exp;
    exp_t e;
    lo = XLEN'(32'h8000_0000); hi = XLEN'(32'h1234_5678); p = {hi, lo};
`ifdef MUL_W_OPS_EN
    w_exp = XLEN'(64'hFFFF_FFFF_8000_0000);
`else
    w_exp = lo;
`endif
    MulResultReadyW = 1'b1;
    sb.push_back('{w_exp, TAGW'(12)});
    sb.push_back('{lo, TAGW'(13)});
    sb.push_back('{hi, TAGW'(14)});
    for (int k = 0; k < 3; k++) begin
      drive_op((k == 2) ? 3'b001 : 3'b000, (k != 1), TAGW'(12 + k), p);
      tick;
      e = sb.pop_front();
      checks++;
      if (MulResultValidW !== 1'b1 || MulResultW !== e.res || MulRdW !== e.rd) begin
        errors++;
        $display("FAIL wops[%0d]: got v=%b res=%h rd=%0d want v=1 res=%h rd=%0d", k, MulResultValidW, MulResultW, MulRdW, e.res, e.rd);
      end
    end
    tick;
  endtask

  task automatic test_reset_mid;
    MulResultReadyW = 1'b0;
    drive_op(3'b000, 1'b0, TAGW'(20), {XLEN'(0), XLEN'(32'hAA)});
    drive_op(3'b000, 1'b0, TAGW'(21), {XLEN'(0), XLEN'(32'hBB)});
    tick;
    checks++; if (MulBusyM !== 1'b1 || MulResultValidW !== 1'b1) begin errors++; $display("FAIL rst_mid_prefill: busy=%b valid=%b want 1 1", MulBusyM, MulResultValidW); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (MulResultValidW !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", MulResultValidW); end
    checks++; if (MulBusyM !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", MulBusyM); end
    checks++; if (MulResultW !== '0 || MulRdW !== '0) begin errors++; $display("FAIL rst_mid_data: got res=%h rd=%0d want 0 0", MulResultW, MulRdW); end
    tick;
    reset_n = 1'b1;
    MulResultReadyW = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++; if (MulResultValidW !== 1'b0) begin errors++; $display("FAIL rst_mid_after[%0d]: valid got %b want 0", k, MulResultValidW); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_select();
    test_back_to_back();
    test_flush_stall();
    test_wops();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
